sme_regex_scan: RTL and testbench
=================================

// Module: sme_regex_scan
// PURPOSE
// - Parametrised string-match engine: stores one string, then answers any number of patterns against it.
// - Patterns support literals and four metacharacters:
//   - '^' : start of string or word.
//   - '$' : end of string or word.
//   - '.' : any single character.
//   - '*' : any run of characters, length 0 or more.
// - Leftmost-match semantics. One result per pattern, reported on a valid pulse.
// - Sits behind the character-stream front end and replaces the fixed 32x8, prefix-only matcher.
// PARAMETERS
// - CHAR_W   8    character width in bits
// - STR_MAX  32   maximum stored string length
// - PAT_MAX  8    maximum pattern length, metacharacters included
// - IDX_W    5    match_index width; must satisfy 2**IDX_W >= STR_MAX
// PORTS
// - clk          in   1        single clock; all logic on posedge
// - reset        in   1        asynchronous, active-low reset (asserted at 0)
// - chardata     in   CHAR_W   character sampled while isstring or ispattern is 1
// - isstring     in   1        string burst, one character per cycle
// - ispattern    in   1        pattern burst, one character per cycle
// - busy         out  1        1 while a search runs; new bursts are ignored
// - valid        out  1        one-cycle pulse when the result is ready
// - match        out  1        1 if the pattern was found
// - match_index  out  IDX_W    start position of the leftmost match; 0 when match=0
// BEHAVIOUR
// - Reset (reset=0), asynchronous:
//   - FSM returns to IDLE.
//   - str_len=0, pat_len=0.
//   - busy=0, valid=0, match=0, match_index=0.
// - States: IDLE, LOAD_STR, LOAD_PAT, HEAD, TAIL, DONE.
//   - IDLE -> LOAD_STR when isstring=1. IDLE -> LOAD_PAT when ispattern=1.
//   - LOAD_STR:
//     - The first character of a burst clears str_len.
//     - Each character is written at str_len, and str_len increments.
//     - Characters past STR_MAX are dropped and str_len saturates.
//     - Returns to IDLE when isstring falls.
//   - LOAD_PAT:
//     - Works like LOAD_STR, with PAT_MAX saturation.
//     - When ispattern falls, the FSM enters HEAD on the next edge and busy rises.
//   - Pattern preprocessing:
//     - Leading '^' sets anchor_l.
//     - Trailing '$' sets anchor_r.
//     - The first '*' splits the pattern into head and tail segments.
//     - Any later '*' is compared literally.
//   - HEAD:
//     - Scans candidate s = 0 .. str_len-1, one position per cycle.
//     - Segment compare at s passes when both hold:
//       - every non-'.' character equals the string character;
//       - s+seg_len <= str_len. Positions past str_len never match; there is no wrap-around.
//     - anchor_l additionally requires s==0 or str[s-1]==0x20.
//     - Without '*', anchor_r additionally requires s+hlen==str_len or str[s+hlen]==0x20.
//     - First pass without '*': match=1, index=s, go to DONE.
//     - First pass with '*': latch s, go to TAIL with t = s+hlen.
//     - Scan exhausted, or empty string: match=0, go to DONE.
//   - TAIL:
//     - Scans t up to str_len-tlen, applying the anchor_r rule to the tail segment.
//     - Pass: match=1, index = latched s, go to DONE.
//     - Exhausted: match=0, go to DONE. No later head can succeed, so no rescan.
//     - Empty tail passes immediately; with anchor_r it needs a space at or after t, or the string end.
//   - DONE: valid=1 for one cycle, busy=0, then IDLE.
//     - match and match_index hold until the next search leaves DONE.
// - Latency: at most 2*STR_MAX+2 cycles from the falling edge of ispattern to valid.
// - Edge cases:
//   - isstring/ispattern while busy: ignored, stored data unchanged.
//   - Both strobes high together: isstring wins.
//   - Empty pattern: match=1, index=0.
//   - Reset mid-search: no valid is emitted.
// CONFIGURATION
// - SME_CASE_FOLD_EN defined:
//   - Literal compares ignore ASCII case: 0x41-0x5A equals 0x61-0x7A.
//   - Metacharacters and the space delimiter are unaffected.
// - SME_CASE_FOLD_EN undefined: exact CHAR_W-bit equality.
// STRUCTURE
// - Package sme_pkg:
//   - Character constants: CH_CARET=0x5E, CH_DOLLAR=0x24, CH_DOT=0x2E, CH_STAR=0x2A, CH_SPACE=0x20.
//   - State enum sme_state_t.
//   - Function chr_eq(), which contains the case-fold option.
// - One sub-module, sme_seg_cmp:
//   - Combinational compare of a PAT_MAX-wide segment (start, length) against the string window at an offset.
//   - Includes both anchor checks.
//   - HEAD and TAIL share one instance.
// TESTING
// - String "hello world", pattern "wor"   -> valid after 7 cycles, match=1, index=6.
// - String "hello world", pattern "^w.r"  -> match=1, index=6.
// - Same string, pattern "^orl"          -> match=0, index=0.
// - String "abc xyz ab", pattern "b*y$"   -> match=0.
// - Same string, pattern "b*z$"          -> match=1, index=1.
// - String of 32 'a' plus 3 extra characters (dropped), pattern "aa$" -> match=1, index=30; back-to-back pattern "x" -> match=0.
// - reset=0 during HEAD -> no valid; next pattern after release -> str_len=0, so match=0.
// - SME_CASE_FOLD_EN defined: string "ABC", pattern "b.$" -> match=1, index=1. Undefined -> match=0.

Source files
------------

// File: rtl/sme_pkg.sv
// sme_pkg: shared definitions for the sme_regex_scan string-match engine.
//   - Character constants for the metacharacters and the word delimiter.
//   - sme_state_t: scan FSM states.
//   - chr_eq(): literal character equality. With SME_CASE_FOLD_EN defined,
//     ASCII upper- and lower-case letters compare equal. Otherwise the
//     comparison is exact.
package sme_pkg;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_STR,
    S_LOAD_PAT,
    S_HEAD,
    S_TAIL,
    S_DONE
  } sme_state_t;

  // Operands are zero-extended to 32 bits so one function serves any CHAR_W.
  function automatic logic chr_eq(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] fa;
    logic [31:0] fb;
    fa = a;
    fb = b;
`ifdef SME_CASE_FOLD_EN
    // Map 'A'..'Z' onto 'a'..'z'. Every other code, including the
    // metacharacters and the space, is left unchanged.
    if (a >= 32'h41 && a <= 32'h5A) fa = a | 32'h20;
    if (b >= 32'h41 && b <= 32'h5A) fb = b | 32'h20;
`endif
    return fa == fb;
  endfunction

endpackage

// File: rtl/sme_seg_cmp.sv
// sme_seg_cmp: combinational compare of one pattern segment against the
// stored string at a given offset.
//   str_i / str_len_i        : stored string and its length
//   pat_i                    : stored pattern
//   seg_start_i / seg_len_i  : segment location inside the pattern
//   offset_i                 : candidate start position in the string
//   anchor_l_en_i            : require a start of string or word at offset_i
//   anchor_r_en_i            : require an end of string or word after the segment
//   pass_o                   : segment matches at offset_i
// The pattern character '.' matches any string character. All other pattern
// characters are compared with chr_eq().
module sme_seg_cmp
  import sme_pkg::*;
#(
  parameter int CHAR_W  = 8,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8
) (
  input  logic [CHAR_W-1:0]                  str_i [STR_MAX],
  input  logic [$clog2(STR_MAX+1)-1:0]       str_len_i,
  input  logic [CHAR_W-1:0]                  pat_i [PAT_MAX],
  input  logic [$clog2(PAT_MAX+1)-1:0]       seg_start_i,
  input  logic [$clog2(PAT_MAX+1)-1:0]       seg_len_i,
  input  logic [$clog2(STR_MAX+1)-1:0]       offset_i,
  input  logic                               anchor_l_en_i,
  input  logic                               anchor_r_en_i,
  output logic                               pass_o
);

  localparam int AW  = 16;
  localparam int SIW = $clog2(STR_MAX);
  localparam int PIW = $clog2(PAT_MAX);
  localparam logic [CHAR_W-1:0] C_DOT   = CHAR_W'(CH_DOT);
  localparam logic [CHAR_W-1:0] C_SPACE = CHAR_W'(CH_SPACE);

  logic [PAT_MAX-1:0] chr_ok;

  // One comparator per pattern slot. Slots at or beyond seg_len_i always pass.
  // Reads outside the string return 0. The fit check below rejects those
  // cases, so the string never wraps around.
  for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_chr
    logic [AW-1:0]     s_idx;
    logic [AW-1:0]     p_idx;
    logic [CHAR_W-1:0] s_chr;
    logic [CHAR_W-1:0] p_chr;
    assign s_idx = AW'(offset_i) + AW'(gi);
    assign p_idx = AW'(seg_start_i) + AW'(gi);
    assign s_chr = (s_idx < AW'(STR_MAX)) ? str_i[s_idx[SIW-1:0]] : '0;
    assign p_chr = (p_idx < AW'(PAT_MAX)) ? pat_i[p_idx[PIW-1:0]] : '0;
    assign chr_ok[gi] = (AW'(gi) >= AW'(seg_len_i)) || (p_chr == C_DOT) ||
                        chr_eq(32'(p_chr), 32'(s_chr));
  end

  logic [AW-1:0]     end_idx;
  logic [AW-1:0]     l_idx;
  logic [CHAR_W-1:0] l_chr;
  logic [CHAR_W-1:0] r_chr;
  logic              fits;
  logic              left_ok;
  logic              right_ok;

  assign end_idx  = AW'(offset_i) + AW'(seg_len_i);
  assign fits     = end_idx <= AW'(str_len_i);
  assign l_idx    = AW'(offset_i) - AW'(1);
  assign l_chr    = ((offset_i != '0) && (l_idx < AW'(STR_MAX))) ? str_i[l_idx[SIW-1:0]] : '0;
  assign r_chr    = (end_idx < AW'(str_len_i)) ? str_i[end_idx[SIW-1:0]] : '0;
  assign left_ok  = (offset_i == '0) || (l_chr == C_SPACE);
  assign right_ok = (end_idx == AW'(str_len_i)) ||
                    ((end_idx < AW'(str_len_i)) && (r_chr == C_SPACE));

  assign pass_o = fits && (&chr_ok) &&
                  (!anchor_l_en_i || left_ok) &&
                  (!anchor_r_en_i || right_ok);

endmodule

// File: rtl/sme_regex_scan.sv
// sme_regex_scan: string-match engine. The engine stores one string and then
// answers any number of patterns against it. A pattern can use '^' (start of
// string or word), '$' (end of string or word), '.' (any one character) and
// one '*' (any run of characters). A search finds the leftmost match.
//   clk          : clock. All logic runs on the rising edge.
//   reset        : asynchronous active-low reset
//   chardata     : character sampled while isstring or ispattern is high
//   isstring     : string burst strobe, one character per cycle
//   ispattern    : pattern burst strobe. The search starts when it falls.
//   busy         : high while a search runs. Strobes are ignored then.
//   valid        : one-cycle pulse when the result is ready
//   match        : the pattern was found
//   match_index  : start of the leftmost match, or 0 when there is no match
// Configuration macro: SME_CASE_FOLD_EN makes literal compares ignore ASCII
// case.
module sme_regex_scan
  import sme_pkg::*;
#(
  parameter int CHAR_W  = 8,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int IDX_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              busy,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index
);

  localparam int SW  = $clog2(STR_MAX+1);
  localparam int PW  = $clog2(PAT_MAX+1);
  localparam int SIW = $clog2(STR_MAX);
  localparam int PIW = $clog2(PAT_MAX);
  localparam logic [CHAR_W-1:0] C_CARET  = CHAR_W'(CH_CARET);
  localparam logic [CHAR_W-1:0] C_DOLLAR = CHAR_W'(CH_DOLLAR);
  localparam logic [CHAR_W-1:0] C_STAR   = CHAR_W'(CH_STAR);

  sme_state_t        state_q, state_d;
  logic [SW-1:0]     str_len_q, str_len_d;
  logic [PW-1:0]     pat_len_q, pat_len_d;
  logic [SW-1:0]     pos_q, pos_d;        // s in HEAD, t in TAIL
  logic [SW-1:0]     head_s_q, head_s_d;  // head position latched for TAIL
  logic              match_q, match_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [CHAR_W-1:0] str_q [STR_MAX];
  logic [CHAR_W-1:0] pat_q [PAT_MAX];
  logic              str_we, pat_we;
  logic [SIW-1:0]    str_waddr;
  logic [PIW-1:0]    pat_waddr;

  // The character stores have no reset. Only the lengths say which
  // characters are meaningful.
  always_ff @(posedge clk) begin
    if (str_we) str_q[str_waddr] <= chardata;
    if (pat_we) pat_q[pat_waddr] <= chardata;
  end

  // Pattern preprocessing, taken combinationally from the stored pattern.
  // The pattern is stable for the whole search because strobes are ignored
  // while busy.
  logic          anchor_l, anchor_r, has_star;
  logic [PW-1:0] body_s, body_e, last_idx, star_pos;
  logic [PW-1:0] hstart, hlen, tstart, tlen;

  always_comb begin
    anchor_l = (pat_len_q != '0) && (pat_q[0] == C_CARET);
    body_s   = anchor_l ? PW'(1) : '0;
    last_idx = pat_len_q - PW'(1);
    // A lone "^" is never also treated as a trailing '$'.
    anchor_r = (pat_len_q > body_s) && (pat_q[last_idx[PIW-1:0]] == C_DOLLAR);
    body_e   = anchor_r ? last_idx : pat_len_q;
    has_star = 1'b0;
    star_pos = body_e;
    // Only the first '*' splits the pattern. Any later '*' stays a literal.
    for (int i = 0; i < PAT_MAX; i++) begin
      if (!has_star && (PW'(i) >= body_s) && (PW'(i) < body_e) && (pat_q[i] == C_STAR)) begin
        has_star = 1'b1;
        star_pos = PW'(i);
      end
    end
    hstart = body_s;
    hlen   = star_pos - body_s;
    tstart = star_pos + PW'(1);
    tlen   = has_star ? (body_e - star_pos - PW'(1)) : '0;
  end

  // One comparator, shared by the HEAD and TAIL scans.
  logic          in_tail;
  logic          seg_pass;
  logic [PW-1:0] seg_start, seg_len;

  assign in_tail   = (state_q == S_TAIL);
  assign seg_start = in_tail ? tstart : hstart;
  assign seg_len   = in_tail ? tlen : hlen;

  sme_seg_cmp #(
    .CHAR_W  (CHAR_W),
    .STR_MAX (STR_MAX),
    .PAT_MAX (PAT_MAX)
  ) u_seg_cmp (
    .str_i         (str_q),
    .str_len_i     (str_len_q),
    .pat_i         (pat_q),
    .seg_start_i   (seg_start),
    .seg_len_i     (seg_len),
    .offset_i      (pos_q),
    .anchor_l_en_i (!in_tail && anchor_l),
    .anchor_r_en_i (anchor_r && (in_tail || !has_star)),
    .pass_o        (seg_pass)
  );

  logic [SW:0] tail_end;
  assign tail_end = {1'b0, pos_q} + (SW+1)'(tlen);

  always_comb begin
    state_d   = state_q;
    str_len_d = str_len_q;
    pat_len_d = pat_len_q;
    pos_d     = pos_q;
    head_s_d  = head_s_q;
    match_d   = match_q;
    idx_d     = idx_q;
    str_we    = 1'b0;
    pat_we    = 1'b0;
    str_waddr = str_len_q[SIW-1:0];
    pat_waddr = pat_len_q[PIW-1:0];

    case (state_q)
      S_IDLE: begin
        // The first character of a burst restarts the buffer at index 0.
        // isstring wins when both strobes are high.
        if (isstring) begin
          str_we    = 1'b1;
          str_waddr = '0;
          str_len_d = SW'(1);
          state_d   = S_LOAD_STR;
        end else if (ispattern) begin
          pat_we    = 1'b1;
          pat_waddr = '0;
          pat_len_d = PW'(1);
          state_d   = S_LOAD_PAT;
        end
      end
      S_LOAD_STR: begin
        if (isstring) begin
          if (str_len_q < SW'(STR_MAX)) begin
            str_we    = 1'b1;
            str_len_d = str_len_q + SW'(1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_PAT: begin
        if (ispattern) begin
          if (pat_len_q < PW'(PAT_MAX)) begin
            pat_we    = 1'b1;
            pat_len_d = pat_len_q + PW'(1);
          end
        end else begin
          pos_d   = '0;
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        if (pat_len_q == '0) begin
          match_d = 1'b1;
          idx_d   = '0;
          state_d = S_DONE;
        end else if (pos_q >= str_len_q) begin
          match_d = 1'b0;
          idx_d   = '0;
          state_d = S_DONE;
        end else if (seg_pass) begin
          if (has_star) begin
            head_s_d = pos_q;
            pos_d    = pos_q + SW'(hlen);
            state_d  = S_TAIL;
          end else begin
            match_d = 1'b1;
            idx_d   = IDX_W'(pos_q);
            state_d = S_DONE;
          end
        end else begin
          pos_d = pos_q + SW'(1);
        end
      end
      S_TAIL: begin
        // A later head start can only shrink the tail's search range, so a
        // tail that fails for the leftmost head fails for all heads.
        if (seg_pass) begin
          match_d = 1'b1;
          idx_d   = IDX_W'(head_s_q);
          state_d = S_DONE;
        end else if (tail_end >= {1'b0, str_len_q}) begin
          match_d = 1'b0;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          pos_d = pos_q + SW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      str_len_q <= '0;
      pat_len_q <= '0;
      pos_q     <= '0;
      head_s_q  <= '0;
      match_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      str_len_q <= str_len_d;
      pat_len_q <= pat_len_d;
      pos_q     <= pos_d;
      head_s_q  <= head_s_d;
      match_q   <= match_d;
      idx_q     <= idx_d;
    end
  end

  assign busy        = (state_q == S_HEAD) || (state_q == S_TAIL);
  assign valid       = (state_q == S_DONE);
  assign match       = match_q;
  assign match_index = idx_q;

endmodule

// File: tb/tb_sme_regex_scan.sv
// tb_sme_regex_scan: directed scoreboard bench for sme_regex_scan.
// The driver pushes the expected result for each pattern. The monitor pops
// one entry on every valid pulse and compares it against the outputs.
module tb_sme_regex_scan;

  logic       clk;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       busy;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  sme_regex_scan #(
    .CHAR_W  (8),
    .STR_MAX (32),
    .PAT_MAX (8),
    .IDX_W   (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .busy        (busy),
    .valid       (valid),
    .match       (match),
    .match_index (match_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    bit    m;
    int    idx;
    int    lat;   // expected latency in cycles, or -1 for no latency check
    int    t0;    // cycle count when ispattern fell
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: one scoreboard entry per valid pulse.
  always @(negedge clk) begin
    if (reset && valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("result %s: match=%0d index=%0d", e.name, match, match_index);
        chk({e.name, ".match"}, int'(match), int'(e.m));
        chk({e.name, ".index"}, int'(match_index), e.idx);
        chk({e.name, ".busy_at_valid"}, int'(busy), 0);
        // The latency count starts at the first edge that samples ispattern
        // low. That edge moves the FSM into the scan.
        if (e.lat >= 0) chk({e.name, ".latency"}, cyc - e.t0 - 1, e.lat);
      end
    end
  end

  task automatic load_string(input string s, input int extra);
    for (int i = 0; i < s.len() + extra; i++) begin
      isstring = 1'b1;
      chardata = (i < s.len()) ? s[i] : 8'h62;  // extra characters are 'b'
      @(negedge clk);
    end
    isstring = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_pattern(input string p, input bit push, input bit m,
                              input int idx, input int lat);
    exp_t e;
    for (int i = 0; i < p.len(); i++) begin
      ispattern = 1'b1;
      chardata  = p[i];
      @(negedge clk);
    end
    ispattern = 1'b0;
    if (push) begin
      e.name = p;
      e.m    = m;
      e.idx  = idx;
      e.lat  = lat;
      e.t0   = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk({name, ".timeout"}, 1, 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input string p, input bit m, input int idx, input int lat);
    send_pattern(p, 1'b1, m, idx, lat);
    wait_done(p);
  endtask

  initial begin
    bit seen;
    reset     = 1'b0;
    isstring  = 1'b0;
    ispattern = 1'b0;
    chardata  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("reset.busy", int'(busy), 0);
    chk("reset.valid", int'(valid), 0);
    chk("reset.match", int'(match), 0);
    chk("reset.index", int'(match_index), 0);
    reset = 1'b1;
    @(negedge clk);

    load_string("hello world", 0);
    run("wor", 1'b1, 6, 7);
    run("^w.r", 1'b1, 6, -1);

    // Strobes sent during a search must not change the stored string.
    send_pattern("^orl", 1'b1, 1'b0, 0, -1);
    @(negedge clk);
    @(negedge clk);
    chk("busy_during_search", int'(busy), 1);
    isstring = 1'b1;
    chardata = 8'h7A;
    @(negedge clk);
    @(negedge clk);
    isstring = 1'b0;
    wait_done("^orl");
    run("hel", 1'b1, 0, -1);

    load_string("abc xyz ab", 0);
    run("b*y$", 1'b0, 0, -1);
    run("b*z$", 1'b1, 1, -1);

    // 32 'a' followed by 3 'b'. The 'b' characters go past STR_MAX and are
    // dropped.
    load_string("aaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa", 3);
    run("aa$", 1'b1, 30, -1);
    run("x", 1'b0, 0, -1);
    run("b", 1'b0, 0, -1);

    load_string("ABC", 0);
`ifdef SME_CASE_FOLD_EN
    run("b.$", 1'b1, 1, -1);
`else
    run("b.$", 1'b0, 0, -1);
`endif

    // Reset during HEAD: no valid may follow, and the string is cleared.
    load_string("hello world", 0);
    send_pattern("wor", 1'b0, 1'b0, 0, -1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset.busy", int'(busy), 0);
    chk("midreset.valid", int'(valid), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    chk("midreset.no_valid", int'(seen), 0);
    run("o", 1'b0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish before 200000");
    $fatal(1);
  end

endmodule
